display_dynamic_scan: RTL and testbench
=======================================

Name: display_dynamic_scan

Overview:
Time-multiplexed driver for an n_dig-digit common-anode/cathode 7-segment display. Successor to the basic dynamic display. Adds the following:
- configurable scan rate
- correct wrap for non-power-of-2 digit counts
- per-digit decimal points
- leading-zero blanking
- PWM brightness control
- frame-coherent input snapshot
- selectable pin polarity

Sits between the core's memory-mapped display register and the board's segment/digit pins.

Parameters:
n_dig, 4, number of digits (>= 2, need not be a power of 2)
refresh_w, 16, width of the slot counter; each digit slot lasts 2^refresh_w clocks
bright_w, 4, width of the brightness input (must be <= refresh_w)
seg_active_low, 1, 1 = segment pins are active-low
dig_active_low, 1, 1 = digit-select pins are active-low

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
number  input  n_dig*4  hex nibbles; number[3:0] is digit 0 (rightmost)
dots  input  n_dig  decimal point per digit; dots[k] lights h of digit k
blank_lz  input  1  1 = blank leading zeros
brightness  input  bright_w  PWM on-level; 0 = dark
abcdefgh  output  8  segments, bit7 = a ... bit1 = g, bit0 = h (dp)
digit  output  n_dig  one-hot digit select, digit[k] = digit k
frame_done  output  1  one-cycle pulse when a full scan frame completes

Behaviour:
- Polarity: internal encoding is 1 = lit / selected. Output bits are inverted when the matching *_active_low parameter is 1.
- Async reset (all registers):
  - cnt = 0, i = 0
  - snapshot (number, dots, blank_lz) = 0
  - abcdefgh = all segments unlit, digit = no digit selected (both at pin-level inactive)
  - frame_done = 0
- cnt: free-running refresh_w-bit counter. tick = (cnt == all ones).
- Slot index i, 0..n_dig-1:
  - On tick, i <= (i == n_dig-1) ? 0 : i+1.
  - i never reaches n_dig.
- Snapshot: on tick with i == n_dig-1, number/dots/blank_lz are copied into snapshot registers and frame_done = 1 for that one cycle.
  - Changes to these inputs mid-frame are invisible until the next frame.
  - brightness is NOT snapshotted; it is sampled live every cycle.
- Leading-zero blank for digit k (k >= 1): snap_blank_lz = 1 AND snapshot nibbles k..n_dig-1 are all 0. Digit 0 is never blanked.
- Segment value for slot i:
  - blanked: bits a..g = 0 (unlit)
  - otherwise: bits a..g = hex glyph of nibble i (0-9, A, b, C, d, E, F)
  - h = snap_dots[i] in both cases; the dp is not suppressed by blanking.
- PWM: pwm_on = (cnt[refresh_w-1 -: bright_w] < brightness).
  - brightness = 2^bright_w-1 gives a duty of (2^bright_w-1)/2^bright_w.
  - During a slot, the digit select is asserted only while pwm_on. Segments are driven regardless.
- Outputs abcdefgh and digit are registered. They reflect the cnt/i/snapshot state of the previous cycle (1-cycle latency).
  - The digit output is one-hot (bit i) or all inactive; never more than one digit is selected.
- Mid-operation reset: all outputs return to inactive immediately (asynchronous). The scan resumes from slot 0 with a zero snapshot.
- The first frame after reset displays the zero snapshot ("0" on digit 0, higher digits showing 0 / blank per the snapshotted blank_lz = 0).

Decomposition:
- Shared package display_pkg holds:
  - seg_t (logic [7:0])
  - glyph constants for 0-F
  - function hex_to_seg returning a..g in active-high form
- One sub-module is natural: display_pwm_prescaler. It contains cnt, emits tick and pwm_on, and is parameterised by refresh_w and bright_w.
- The top module holds the slot index, snapshot, blanking logic and output registers.

Test Plan:
1. Reset check, with refresh_w=4, bright_w=2, n_dig=4, both polarities = 1 → during reset and in the first cycle after it: abcdefgh = 8'hFF, digit = 4'hF, frame_done = 0.
2. Snapshot load, with number=16'h12AF, dots=4'b0100, brightness=3, after the first frame_done → over each 16-clock slot:
   - digit pins read 1110, 1101, 1011, 0111 in turn, for 12 of 16 clocks each
   - segments read glyphs F, A, 2, 1 (inverted), in that order
   - dp is lit only on digit 2
3. Non-power-of-2 wrap, with n_dig=3 → i runs 0, 1, 2, 0; digit never reads an invalid code; frame_done pulses every 48 clocks.
4. Leading-zero blanking, with number=16'h0050, blank_lz=1 → digits 3 and 2 are unlit, digit 1 shows 5, digit 0 shows 0. With number=0 → only digit 0 shows 0.
5. Brightness sweep 0..3 → digit-asserted clocks per slot are 0, 4, 8, 12. A brightness change takes effect within 1 clock, not at the frame boundary.
6. Mid-frame change plus reset: change number during slot 1 → the display is unchanged until the next frame_done. Assert reset mid-slot → outputs are inactive in the same cycle, and the scan restarts at digit 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   seg_t      : 8-bit segment word, bit7 = a ... bit1 = g, bit0 = h (dp)
//   GLYPH_*    : a..g patterns for hex digits, 1 = lit
//   hex_to_seg : nibble -> a..g pattern, active-high
package display_pkg;

   typedef logic [7:0] seg_t;

   localparam logic [6:0] GLYPH_0 = 7'h7E;
   localparam logic [6:0] GLYPH_1 = 7'h30;
   localparam logic [6:0] GLYPH_2 = 7'h6D;
   localparam logic [6:0] GLYPH_3 = 7'h79;
   localparam logic [6:0] GLYPH_4 = 7'h33;
   localparam logic [6:0] GLYPH_5 = 7'h5B;
   localparam logic [6:0] GLYPH_6 = 7'h5F;
   localparam logic [6:0] GLYPH_7 = 7'h70;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h7B;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h1F;  // lower-case b
   localparam logic [6:0] GLYPH_C = 7'h4E;
   localparam logic [6:0] GLYPH_D = 7'h3D;  // lower-case d
   localparam logic [6:0] GLYPH_E = 7'h4F;
   localparam logic [6:0] GLYPH_F = 7'h47;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = GLYPH_0;
         4'h1:    g = GLYPH_1;
         4'h2:    g = GLYPH_2;
         4'h3:    g = GLYPH_3;
         4'h4:    g = GLYPH_4;
         4'h5:    g = GLYPH_5;
         4'h6:    g = GLYPH_6;
         4'h7:    g = GLYPH_7;
         4'h8:    g = GLYPH_8;
         4'h9:    g = GLYPH_9;
         4'hA:    g = GLYPH_A;
         4'hB:    g = GLYPH_B;
         4'hC:    g = GLYPH_C;
         4'hD:    g = GLYPH_D;
         4'hE:    g = GLYPH_E;
         default: g = GLYPH_F;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/display_pwm_prescaler.sv
// Free-running slot counter with PWM compare.
//   clk, reset  : clock, asynchronous active-high reset
//   brightness  : PWM on-level, sampled live (0 = always off)
//   tick        : high in the last clock of every 2^refresh_w-clock slot
//   pwm_on      : high while the top bright_w counter bits are below brightness
module display_pwm_prescaler #(
   parameter int refresh_w = 16,
   parameter int bright_w  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [bright_w-1:0] brightness,
   output logic                tick,
   output logic                pwm_on
);

   localparam logic [refresh_w-1:0] CNT_ONE = refresh_w'(1);

   logic [refresh_w-1:0] cnt_q;
   logic [refresh_w-1:0] cnt_d;

   assign cnt_d = cnt_q + CNT_ONE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = &cnt_q;

   // Comparing the counter's top bits makes each brightness step one
   // 2^(refresh_w-bright_w)-clock chunk of the slot.
   assign pwm_on = (cnt_q[refresh_w-1 -: bright_w] < brightness);

endmodule

// File: rtl/display_dynamic_scan.sv
// Time-multiplexed n_dig-digit 7-segment driver.
//   clk, reset  : clock, asynchronous active-high reset
//   number      : hex nibbles, number[3:0] is digit 0 (rightmost)
//   dots        : decimal point per digit
//   blank_lz    : 1 = blank leading zeros (digit 0 always shown)
//   brightness  : PWM on-level, live
//   abcdefgh    : registered segment pins (bit7 = a, bit0 = dp)
//   digit       : registered one-hot digit select pins, or all inactive
//   frame_done  : one-cycle pulse when a new snapshot is taken
module display_dynamic_scan
   import display_pkg::*;
#(
   parameter int n_dig          = 4,
   parameter int refresh_w      = 16,
   parameter int bright_w       = 4,
   parameter bit seg_active_low = 1'b1,
   parameter bit dig_active_low = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [n_dig*4-1:0]   number,
   input  logic [n_dig-1:0]     dots,
   input  logic                 blank_lz,
   input  logic [bright_w-1:0]  brightness,
   output logic [7:0]           abcdefgh,
   output logic [n_dig-1:0]     digit,
   output logic                 frame_done
);

   localparam int                IDX_W    = $clog2(n_dig);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(n_dig - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
   // Pin-level "off" words; XOR with these converts internal 1 = lit to pins.
   localparam seg_t              SEG_OFF  = {8{seg_active_low}};
   localparam logic [n_dig-1:0]  DIG_OFF  = {n_dig{dig_active_low}};

   logic tick;
   logic pwm_on;

   display_pwm_prescaler #(
      .refresh_w (refresh_w),
      .bright_w  (bright_w)
   ) u_prescaler (
      .clk        (clk),
      .reset      (reset),
      .brightness (brightness),
      .tick       (tick),
      .pwm_on     (pwm_on)
   );

   logic [IDX_W-1:0]   i_q, i_d;
   logic [n_dig*4-1:0] snap_number_q;
   logic [n_dig-1:0]   snap_dots_q;
   logic               snap_blz_q;
   seg_t               abcdefgh_q, abcdefgh_d;
   logic [n_dig-1:0]   digit_q, digit_d;
   logic               frame_done_q;
   logic               frame_end;

   assign frame_end = tick & (i_q == LAST_IDX);
   assign i_d       = tick ? ((i_q == LAST_IDX) ? '0 : i_q + IDX_ONE) : i_q;

   logic [n_dig-1:0] blank;
   logic             zero_above;
   logic [3:0]       nib;
   logic             dp;
   logic             blank_cur;
   logic [n_dig-1:0] sel;
   seg_t             seg_lit;

   always_comb begin
      // Walk from the most significant digit down; a digit is blanked only
      // while every digit from it upward is zero.
      blank      = '0;
      zero_above = snap_blz_q;
      for (int k = n_dig - 1; k >= 1; k--) begin
         zero_above = zero_above & (snap_number_q[k*4 +: 4] == 4'h0);
         blank[k]   = zero_above;
      end

      nib       = 4'h0;
      dp        = 1'b0;
      blank_cur = 1'b0;
      sel       = '0;
      for (int k = 0; k < n_dig; k++) begin
         if (i_q == IDX_W'(k)) begin
            nib       = snap_number_q[k*4 +: 4];
            dp        = snap_dots_q[k];
            blank_cur = blank[k];
            sel[k]    = 1'b1;
         end
      end

      // The dp is kept even on a blanked digit.
      seg_lit    = {(blank_cur ? 7'h00 : hex_to_seg(nib)), dp};
      abcdefgh_d = seg_lit ^ SEG_OFF;
      digit_d    = (pwm_on ? sel : '0) ^ DIG_OFF;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i_q           <= '0;
         snap_number_q <= '0;
         snap_dots_q   <= '0;
         snap_blz_q    <= 1'b0;
         abcdefgh_q    <= SEG_OFF;
         digit_q       <= DIG_OFF;
         frame_done_q  <= 1'b0;
      end else begin
         i_q <= i_d;
         if (frame_end) begin
            snap_number_q <= number;
            snap_dots_q   <= dots;
            snap_blz_q    <= blank_lz;
         end
         frame_done_q <= frame_end;
         abcdefgh_q   <= abcdefgh_d;
         digit_q      <= digit_d;
      end
   end

   assign abcdefgh   = abcdefgh_q;
   assign digit      = digit_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_dynamic_scan.sv
module tb_display_dynamic_scan;

   // Clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 4-digit DUT, active-low pins
   logic [15:0] number;
   logic [3:0]  dots;
   logic        blank_lz;
   logic [1:0]  brightness;
   logic [7:0]  seg4;
   logic [3:0]  dig4;
   logic        fd4;

   // 3-digit DUT, active-high pins
   logic [11:0] number3;
   logic [2:0]  dots3;
   logic        blank_lz3;
   logic [1:0]  brightness3;
   logic [7:0]  seg3;
   logic [2:0]  dig3;
   logic        fd3;

   display_dynamic_scan #(
      .n_dig(4), .refresh_w(4), .bright_w(2),
      .seg_active_low(1'b1), .dig_active_low(1'b1)
   ) dut4 (
      .clk(clk), .reset(reset), .number(number), .dots(dots),
      .blank_lz(blank_lz), .brightness(brightness),
      .abcdefgh(seg4), .digit(dig4), .frame_done(fd4)
   );

   display_dynamic_scan #(
      .n_dig(3), .refresh_w(4), .bright_w(2),
      .seg_active_low(1'b0), .dig_active_low(1'b0)
   ) dut3 (
      .clk(clk), .reset(reset), .number(number3), .dots(dots3),
      .blank_lz(blank_lz3), .brightness(brightness3),
      .abcdefgh(seg3), .digit(dig3), .frame_done(fd3)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Driver helpers: bounded waits for the frame pulse
   task automatic wait_frame4(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (fd4 !== 1'b1 && cyc < 200);
      checks++;
      if (fd4 !== 1'b1) begin
         failures++;
         $display("FAIL frame_done4 timeout: none in %0d cycles, expected within 200", cyc);
      end
   endtask

   task automatic wait_frame3(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (fd3 !== 1'b1 && cyc < 200);
      checks++;
      if (fd3 !== 1'b1) begin
         failures++;
         $display("FAIL frame_done3 timeout: none in %0d cycles, expected within 200", cyc);
      end
   endtask

   // Vector record: inputs, optional mid-frame number change, expected pins
   typedef struct packed {
      logic [15:0] num;
      logic [3:0]  dp;
      logic        blz;
      logic [1:0]  bri;
      logic        chg_en;
      logic [15:0] chg_num;
      logic [31:0] exp_seg;   // {slot3, slot2, slot1, slot0}, pin level
      logic [4:0]  exp_on;    // digit-asserted clocks per slot
   } vec_t;

   vec_t vecs[6];

   // Apply one vector, wait for its snapshot, then scan one whole frame.
   task automatic run_vec4(input vec_t v, input int vi);
      int          cyc;
      int          on_cnt, seg_bad, dig_bad, fd_bad;
      logic [7:0]  seg_first;
      logic [3:0]  exp_dig;
      logic        exp_fd;
      number     = v.num;
      dots       = v.dp;
      blank_lz   = v.blz;
      brightness = v.bri;
      wait_frame4(cyc);
      fd_bad = 0;
      for (int s = 0; s < 4; s++) begin
         on_cnt    = 0;
         seg_bad   = 0;
         dig_bad   = 0;
         seg_first = 8'h00;
         exp_dig   = ~(4'b0001 << s);
         for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (j == 0) seg_first = seg4;
            if (seg4 !== v.exp_seg[s*8 +: 8]) seg_bad++;
            if (dig4 === exp_dig) on_cnt++;
            else if (dig4 !== 4'hF) dig_bad++;
            exp_fd = (s == 3 && j == 15);
            if (fd4 !== exp_fd) fd_bad++;
         end
         if (s == 0 && v.chg_en) number = v.chg_num;
         check($sformatf("v%0d slot%0d seg", vi, s), seg_first, v.exp_seg[s*8 +: 8]);
         check($sformatf("v%0d slot%0d seg_unstable_count", vi, s), seg_bad, 0);
         check($sformatf("v%0d slot%0d bad_digit_code_count", vi, s), dig_bad, 0);
         check($sformatf("v%0d slot%0d digit_on_clocks", vi, s), on_cnt, v.exp_on);
      end
      check($sformatf("v%0d frame_done_misplaced_count", vi), fd_bad, 0);
   endtask

   initial begin
      int         cyc;
      int         on_cnt, dig_bad, seg_bad, fd_bad;
      logic [2:0] exp_dig3;
      logic [23:0] exp_seg3;
      logic        exp_fd;

      vecs[0] = '{16'h12AF, 4'b0100, 1'b0, 2'd3, 1'b1, 16'hFFFF, {8'h9F, 8'h24, 8'h11, 8'h71}, 5'd12};
      vecs[1] = '{16'h0050, 4'b0000, 1'b1, 2'd2, 1'b0, 16'h0000, {8'hFF, 8'hFF, 8'h49, 8'h03}, 5'd8};
      vecs[2] = '{16'h0000, 4'b1000, 1'b1, 2'd1, 1'b0, 16'h0000, {8'hFE, 8'hFF, 8'hFF, 8'h03}, 5'd4};
      vecs[3] = '{16'h0000, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000, {8'h03, 8'h03, 8'h03, 8'h03}, 5'd0};
      vecs[4] = '{16'h9E0B, 4'b0001, 1'b1, 2'd2, 1'b1, 16'h0000, {8'h09, 8'h61, 8'h03, 8'hC0}, 5'd8};
      vecs[5] = '{16'h0300, 4'b0010, 1'b1, 2'd3, 1'b0, 16'h0000, {8'hFF, 8'h0D, 8'h02, 8'h03}, 5'd12};

      reset       = 1'b1;
      number      = '0;
      dots        = '0;
      blank_lz    = 1'b0;
      brightness  = '0;
      number3     = '0;
      dots3       = '0;
      blank_lz3   = 1'b0;
      brightness3 = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst seg4", seg4, 8'hFF);
      check("rst dig4", dig4, 4'hF);
      check("rst fd4", fd4, 1'b0);
      check("rst seg3", seg3, 8'h00);
      check("rst dig3", dig3, 3'b000);
      check("rst fd3", fd3, 1'b0);
      reset = 1'b0;
      #1;
      check("post-rst seg4", seg4, 8'hFF);
      check("post-rst dig4", dig4, 4'hF);
      @(negedge clk);
      // First registered cycle shows the zero snapshot on digit 0, dark.
      check("first seg4", seg4, 8'h03);
      check("first dig4", dig4, 4'hF);
      check("first fd4", fd4, 1'b0);
      check("first seg3", seg3, 8'hFC);
      check("first dig3", dig3, 3'b000);

      // 3-digit DUT: wrap and period
      wait_frame3(cyc);
      check("dut3 first frame latency", cyc, 47);
      number3     = 12'h7C4;
      dots3       = 3'b010;
      blank_lz3   = 1'b0;
      brightness3 = 2'd3;
      wait_frame3(cyc);
      check("dut3 frame period a", cyc, 48);
      exp_seg3 = {8'hE0, 8'h9D, 8'h66};
      fd_bad   = 0;
      for (int s = 0; s < 3; s++) begin
         on_cnt   = 0;
         dig_bad  = 0;
         seg_bad  = 0;
         exp_dig3 = 3'b001 << s;
         for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (seg3 !== exp_seg3[s*8 +: 8]) seg_bad++;
            if (dig3 === exp_dig3) on_cnt++;
            else if (dig3 !== 3'b000) dig_bad++;
            exp_fd = (s == 2 && j == 15);
            if (fd3 !== exp_fd) fd_bad++;
         end
         check($sformatf("dut3 slot%0d seg_bad_count", s), seg_bad, 0);
         check($sformatf("dut3 slot%0d bad_digit_code_count", s), dig_bad, 0);
         check($sformatf("dut3 slot%0d digit_on_clocks", s), on_cnt, 12);
      end
      check("dut3 frame_done_misplaced_count", fd_bad, 0);
      wait_frame3(cyc);
      check("dut3 frame period b", cyc, 48);

      // 4-digit DUT: table of vectors
      for (int vi = 0; vi < 6; vi++) begin
         run_vec4(vecs[vi], vi);
      end

      // Live brightness: we are at the frame_done sample; slot 0 starts next.
      brightness = 2'd0;
      @(negedge clk);                       // cnt = 0
      check("bri0 dig", dig4, 4'hF);
      brightness = 2'd3;
      @(negedge clk);                       // cnt = 1
      check("bri3 dig", dig4, 4'hE);
      brightness = 2'd1;
      @(negedge clk);                       // cnt = 2
      check("bri1 cnt2 dig", dig4, 4'hE);
      @(negedge clk);                       // cnt = 3
      check("bri1 cnt3 dig", dig4, 4'hE);
      @(negedge clk);                       // cnt = 4, past the level
      check("bri1 cnt4 dig", dig4, 4'hF);
      brightness = 2'd3;
      @(negedge clk);                       // cnt = 5
      check("pre-reset dig", dig4, 4'hE);

      // Mid-slot reset: outputs must drop without waiting for an edge.
      #2;
      reset = 1'b1;
      #1;
      check("midrst seg4", seg4, 8'hFF);
      check("midrst dig4", dig4, 4'hF);
      check("midrst fd4", fd4, 1'b0);
      check("midrst seg3", seg3, 8'h00);
      check("midrst dig3", dig3, 3'b000);
      @(negedge clk);
      check("midrst held dig4", dig4, 4'hF);
      reset = 1'b0;
      @(negedge clk);
      check("restart seg4", seg4, 8'h03);
      check("restart dig4 slot0", dig4, 4'hE);
      repeat (16) @(negedge clk);
      check("restart seg4 slot1", seg4, 8'h03);
      check("restart dig4 slot1", dig4, 4'hD);
      wait_frame4(cyc);
      check("restart frame latency", cyc, 47);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
